// File: rtl/pygmy_cfg.sv
// Global sizing constants shared by the cache interface and its clients.
package pygmy_cfg;

  localparam int PADDR_WIDTH      = 32;
  localparam int CACHE_LINE_WIDTH = 512;
  localparam int CPU_TID_WIDTH    = 4;
  localparam int CPU_SRC_WIDTH    = 2;

endpackage

// File: rtl/pygmy_typedef.sv
// Request/response payloads and request-type encodings of cpu_cache_if.
package pygmy_typedef;
  import pygmy_cfg::*;

  localparam int REQ_TYPE_WIDTH = 3;
  typedef logic [REQ_TYPE_WIDTH-1:0] req_type_t;

  localparam req_type_t REQ_READ         = 3'd0;
  localparam req_type_t REQ_WRITE        = 3'd1;
  localparam req_type_t REQ_BARRIER_SYNC = 3'd2;

  // Transaction id: requester source plus a per-source sequence number.
  typedef struct packed {
    logic [CPU_SRC_WIDTH-1:0] src;
    logic [CPU_TID_WIDTH-1:0] tid;
  } cpu_cache_if_tid_t;

  typedef struct packed {
    req_type_t                   req_type;
    cpu_cache_if_tid_t           tid;
    logic [PADDR_WIDTH-1:0]      paddr;
    logic [CACHE_LINE_WIDTH-1:0] data;
  } cpu_cache_if_req_t;

  typedef struct packed {
    cpu_cache_if_tid_t           tid;
    logic [CACHE_LINE_WIDTH-1:0] data;
  } cpu_cache_if_resp_t;

endpackage

// File: rtl/usb_dma_req_seq_pkg.sv
// USB DMA request sequencer types: FSM state encoding and source id.
package usb_dma_req_seq_pkg;
  import pygmy_cfg::*;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_DRAIN     = 3'd2,
    S_SYNC      = 3'd3,
    S_SYNC_WAIT = 3'd4,
    S_DONE      = 3'd5
  } usb_dma_state_e;

  // The USB DMA path owns port 0 of the ROB arbiter.
  localparam logic [CPU_SRC_WIDTH-1:0] USB_DMA_SRC_ID = '0;

endpackage

// File: rtl/usb_dma_ostd_cnt.sv
// Up/down counter of requests in flight with full/empty flags.
// The caller guarantees inc is never raised while full.
module usb_dma_ostd_cnt #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         empty
);

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - W'(1);
    end
  end

  // Flags decoded straight from the count register.
  always_comb begin
    full  = (cnt == W'(MAX));
    empty = (cnt == '0);
  end

endmodule

// File: rtl/usb_dma_req_seq.sv
// Splits one DMA burst descriptor into per-line cpu_cache_if requests,
// tracks outstanding responses, closes write bursts with a barrier and
// pulses done once the burst has fully completed.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. A producer holding valid keeps its payload stable
// until ready; valid never depends combinationally on the ready it waits on.
module usb_dma_req_seq
  import pygmy_cfg::*;
  import pygmy_typedef::*;
  import usb_dma_req_seq_pkg::*;
#(
  parameter int                       MAX_OUTSTANDING = 4,
  parameter int                       LEN_W           = 8,
  parameter int                       LINE_BYTES      = 64,
  parameter logic [CPU_SRC_WIDTH-1:0] SRC_ID          = USB_DMA_SRC_ID
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic                        desc_write,
  input  logic [PADDR_WIDTH-1:0]      desc_addr,
  input  logic [LEN_W-1:0]            desc_lines,
  input  logic                        wdata_valid,
  output logic                        wdata_ready,
  input  logic [CACHE_LINE_WIDTH-1:0] wdata,
  output logic                        req_valid,
  input  logic                        req_ready,
  output cpu_cache_if_req_t           req,
  input  logic                        resp_valid,
  output logic                        resp_ready,
  input  cpu_cache_if_resp_t          resp,
  output logic                        rdata_valid,
  output logic [CACHE_LINE_WIDTH-1:0] rdata,
  output logic                        busy,
  output logic                        done,
  output logic                        err_unexp,
  output logic [2:0]                  state_dbg
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  usb_dma_state_e             state;
  logic                       wr_q;
  logic [PADDR_WIDTH-1:0]     base_q;
  logic [PADDR_WIDTH-1:0]     cur_q;
  logic [LEN_W-1:0]           rem_q;
  logic [CPU_TID_WIDTH-1:0]   tid_q;
  logic                       err_q;

  logic [CW-1:0]              ostd_cnt;
  logic                       ostd_full;
  logic                       ostd_empty;

  logic                       req_hs;
  logic                       desc_hs;
  logic                       resp_src_ok;
  logic                       resp_match;
  logic                       resp_unexp;
  logic                       drain_last;
  logic                       unused_resp_tid;

  // Response classification: a response counts only if it carries our
  // source id and something is actually in flight.
  always_comb begin
    desc_hs     = desc_valid & desc_ready;
    req_hs      = req_valid & req_ready;
    resp_src_ok = (resp.tid.src == SRC_ID);
    resp_match  = resp_valid & resp_src_ok & ~ostd_empty;
    resp_unexp  = resp_valid & ~(resp_src_ok & ~ostd_empty);
    // Leave DRAIN in the same cycle the final response lands.
    drain_last  = ostd_empty | ((ostd_cnt == CW'(1)) & resp_match);
  end

  // Response ids are not matched against issued tids: arrival order is
  // the completion order, so only the source field matters.
  assign unused_resp_tid = ^resp.tid.tid;

  usb_dma_ostd_cnt #(
    .MAX (MAX_OUTSTANDING),
    .W   (CW)
  ) u_ostd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (req_hs),
    .dec   (resp_match),
    .cnt   (ostd_cnt),
    .full  (ostd_full),
    .empty (ostd_empty)
  );

  // Request generation; payload is zero whenever no request is offered.
  always_comb begin
    req_valid = 1'b0;
    req       = '0;
    case (state)
      S_ISSUE: req_valid = ~ostd_full & (~wr_q | wdata_valid);
      S_SYNC:  req_valid = ~ostd_full;
      default: req_valid = 1'b0;
    endcase
    if (req_valid) begin
      req.tid.src = SRC_ID;
      req.tid.tid = tid_q;
      if (state == S_SYNC) begin
        req.req_type = REQ_BARRIER_SYNC;
        req.paddr    = base_q;
      end else begin
        req.req_type = wr_q ? REQ_WRITE : REQ_READ;
        req.paddr    = cur_q;
        req.data     = wr_q ? wdata : '0;
      end
    end
  end

  // Status outputs and pass-through of read data.
  always_comb begin
    desc_ready  = (state == S_IDLE);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    resp_ready  = 1'b1;
    wdata_ready = req_hs & wr_q & (state == S_ISSUE);
    rdata_valid = resp_match & ~wr_q;
    rdata       = rdata_valid ? resp.data : '0;
    err_unexp   = err_q;
    state_dbg   = state;
  end

  // Burst sequencing FSM with its address, length and tid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      wr_q   <= 1'b0;
      base_q <= '0;
      cur_q  <= '0;
      rem_q  <= '0;
      tid_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (desc_valid) begin
            wr_q   <= desc_write;
            base_q <= desc_addr;
            cur_q  <= desc_addr;
            rem_q  <= desc_lines;
            state  <= (desc_lines == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (req_hs) begin
            cur_q <= cur_q + PADDR_WIDTH'(LINE_BYTES);
            tid_q <= tid_q + CPU_TID_WIDTH'(1);
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_last) begin
            state <= wr_q ? S_SYNC : S_DONE;
          end
        end
        S_SYNC: begin
          if (req_hs) begin
            tid_q <= tid_q + CPU_TID_WIDTH'(1);
            state <= S_SYNC_WAIT;
          end
        end
        S_SYNC_WAIT: begin
          if (resp_match) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky unexpected-response flag, cleared by the next accepted burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (resp_unexp) begin
      err_q <= 1'b1;
    end else if (desc_hs) begin
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_dma_req_seq.sv
// Directed bench for usb_dma_req_seq: read, write+barrier, backpressure,
// zero-length, address wrap, foreign source and mid-burst reset.
module tb_usb_dma_req_seq;
  import pygmy_cfg::*;
  import pygmy_typedef::*;
  import usb_dma_req_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                        desc_valid;
  logic                        desc_ready;
  logic                        desc_write;
  logic [PADDR_WIDTH-1:0]      desc_addr;
  logic [7:0]                  desc_lines;
  logic                        wdata_valid;
  logic                        wdata_ready;
  logic [CACHE_LINE_WIDTH-1:0] wdata;
  logic                        req_valid;
  logic                        req_ready;
  cpu_cache_if_req_t           req;
  logic                        resp_valid;
  logic                        resp_ready;
  cpu_cache_if_resp_t          resp;
  logic                        rdata_valid;
  logic [CACHE_LINE_WIDTH-1:0] rdata;
  logic                        busy;
  logic                        done;
  logic                        err_unexp;
  logic [2:0]                  state_dbg;

  usb_dma_req_seq dut (
    .clk         (clk),
    .rst         (rst),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_write  (desc_write),
    .desc_addr   (desc_addr),
    .desc_lines  (desc_lines),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req         (req),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp        (resp),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .busy        (busy),
    .done        (done),
    .err_unexp   (err_unexp),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp;
  int n_err;

  logic [CACHE_LINE_WIDTH-1:0] d0;
  logic [CACHE_LINE_WIDTH-1:0] d1;
  logic [CACHE_LINE_WIDTH-1:0] d2;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    desc_valid  = 1'b0;
    desc_write  = 1'b0;
    desc_addr   = '0;
    desc_lines  = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp        = '0;
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic send_desc(input logic wr, input logic [31:0] addr, input logic [7:0] lines);
    desc_valid = 1'b1;
    desc_write = wr;
    desc_addr  = addr;
    desc_lines = lines;
  endtask

  task automatic drive_resp(input logic [1:0] src, input logic [3:0] id,
                            input logic [CACHE_LINE_WIDTH-1:0] d);
    resp_valid   = 1'b1;
    resp.tid.src = src;
    resp.tid.tid = id;
    resp.data    = d;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    d0 = {16{32'hD0D0_0001}};
    d1 = {16{32'hD1D1_0002}};
    d2 = {16{32'hD2D2_0003}};
    clear_inputs();
    rst = 1'b1;

    // Reset values, no clock edge needed.
    #3;
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_resp_ready", resp_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_unexp, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_state", state_dbg, S_IDLE);

    // ---- Read burst: 3 lines at 0x1000 ----
    apply_reset();
    send_desc(1'b0, 32'h1000, 8'd3);
    req_ready = 1'b1;
    #1;
    chk("rd_desc_ready", desc_ready, 1);
    cyc(); desc_valid = 1'b0; #1;
    chk("rd_r0_valid", req_valid, 1);
    chk("rd_r0_type", req.req_type, REQ_READ);
    chk("rd_r0_addr", req.paddr, 32'h1000);
    chk("rd_r0_tid", req.tid.tid, 0);
    chk("rd_r0_src", req.tid.src, 0);
    chk("rd_busy", busy, 1);
    cyc(); #1;
    chk("rd_r1_addr", req.paddr, 32'h1040);
    chk("rd_r1_tid", req.tid.tid, 1);
    cyc(); #1;
    chk("rd_r2_addr", req.paddr, 32'h1080);
    chk("rd_r2_tid", req.tid.tid, 2);
    cyc(); drive_resp(2'd0, 4'd0, d0); #1;
    chk("rd_drain_no_req", req_valid, 0);
    chk("rd_rv0", rdata_valid, 1);
    chk("rd_rdata0", rdata, d0);
    cyc(); drive_resp(2'd0, 4'd1, d1); #1;
    chk("rd_rdata1", rdata, d1);
    cyc(); drive_resp(2'd0, 4'd2, d2); #1;
    chk("rd_rv2", rdata_valid, 1);
    chk("rd_rdata2", rdata, d2);
    chk("rd_done_early", done, 0);
    cyc(); resp_valid = 1'b0; #1;
    chk("rd_done", done, 1);
    chk("rd_no_barrier", req_valid, 0);
    cyc(); #1;
    chk("rd_done_pulse", done, 0);
    chk("rd_idle", busy, 0);

    // ---- Write burst: 2 lines then barrier ----
    apply_reset();
    send_desc(1'b1, 32'h2000, 8'd2);
    req_ready   = 1'b1;
    wdata_valid = 1'b1;
    wdata       = d1;
    cyc(); desc_valid = 1'b0; #1;
    chk("wr_w0_valid", req_valid, 1);
    chk("wr_w0_type", req.req_type, REQ_WRITE);
    chk("wr_w0_data", req.data, d1);
    chk("wr_w0_wready", wdata_ready, 1);
    chk("wr_w0_tid", req.tid.tid, 0);
    cyc(); wdata = d2; #1;
    chk("wr_w1_addr", req.paddr, 32'h2040);
    chk("wr_w1_data", req.data, d2);
    chk("wr_w1_tid", req.tid.tid, 1);
    cyc(); wdata_valid = 1'b0; drive_resp(2'd0, 4'd0, '0); #1;
    chk("wr_drain_no_req", req_valid, 0);
    chk("wr_drain_no_wready", wdata_ready, 0);
    chk("wr_no_rdata", rdata_valid, 0);
    cyc(); drive_resp(2'd0, 4'd1, '0); #1;
    chk("wr_no_early_barrier", req_valid, 0);
    cyc(); resp_valid = 1'b0; #1;
    chk("wr_bar_valid", req_valid, 1);
    chk("wr_bar_type", req.req_type, REQ_BARRIER_SYNC);
    chk("wr_bar_addr", req.paddr, 32'h2000);
    chk("wr_bar_tid", req.tid.tid, 2);
    cyc(); #1;
    chk("wr_syncwait_no_req", req_valid, 0);
    chk("wr_syncwait_no_done", done, 0);
    drive_resp(2'd0, 4'd2, '0);
    cyc(); resp_valid = 1'b0; #1;
    chk("wr_done", done, 1);

    // ---- Backpressure: 8 lines, responses withheld ----
    apply_reset();
    send_desc(1'b0, 32'h4000, 8'd8);
    req_ready = 1'b1;
    cyc(); desc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_fill_valid", req_valid, 1);
      chk("bp_fill_tid", req.tid.tid, i);
      cyc();
    end
    #1;
    chk("bp_full_stall", req_valid, 0);
    cyc(); #1;
    chk("bp_full_hold", req_valid, 0);
    drive_resp(2'd0, 4'd0, d0); #1;
    chk("bp_full_resp_cycle", req_valid, 0);
    // Response and request handshake together: count must stay at 3.
    cyc(); drive_resp(2'd0, 4'd1, d1); #1;
    chk("bp_release_valid", req_valid, 1);
    chk("bp_release_tid", req.tid.tid, 4);
    chk("bp_release_addr", req.paddr, 32'h4100);
    cyc(); resp_valid = 1'b0; #1;
    chk("bp_simul_valid", req_valid, 1);
    chk("bp_simul_tid", req.tid.tid, 5);
    cyc(); #1;
    chk("bp_refull_stall", req_valid, 0);

    // ---- Zero-length descriptor ----
    apply_reset();
    send_desc(1'b0, 32'h8000, 8'd0);
    req_ready = 1'b1;
    cyc(); desc_valid = 1'b0; #1;
    chk("z_done", done, 1);
    chk("z_no_req", req_valid, 0);
    cyc(); #1;
    chk("z_done_pulse", done, 0);
    chk("z_idle", desc_ready, 1);

    // ---- Address wrap at top of physical space ----
    apply_reset();
    send_desc(1'b0, 32'hFFFF_FFC0, 8'd2);
    req_ready = 1'b1;
    cyc(); desc_valid = 1'b0; #1;
    chk("wrap_a0", req.paddr, 32'hFFFF_FFC0);
    cyc(); #1;
    chk("wrap_a1", req.paddr, 32'h0);
    chk("wrap_tid1", req.tid.tid, 1);

    // ---- Foreign source response ----
    apply_reset();
    send_desc(1'b0, 32'h3000, 8'd1);
    req_ready = 1'b1;
    cyc(); desc_valid = 1'b0; #1;
    chk("src_req_valid", req_valid, 1);
    cyc(); drive_resp(2'd1, 4'd0, d0); #1;
    chk("src_bad_no_rdata", rdata_valid, 0);
    cyc(); drive_resp(2'd0, 4'd0, d1); #1;
    chk("src_err_set", err_unexp, 1);
    chk("src_still_busy", busy, 1);
    chk("src_good_rdata", rdata, d1);
    cyc(); resp_valid = 1'b0; #1;
    chk("src_done", done, 1);
    chk("src_err_sticky", err_unexp, 1);
    cyc(); send_desc(1'b0, 32'h0, 8'd0);
    cyc(); desc_valid = 1'b0; #1;
    chk("src_err_cleared", err_unexp, 0);

    // ---- Reset mid-burst, then a stale response ----
    apply_reset();
    send_desc(1'b0, 32'h5000, 8'd5);
    req_ready = 1'b1;
    cyc(); desc_valid = 1'b0;
    cyc();
    cyc(); #1;
    chk("mr_third_valid", req_valid, 1);
    chk("mr_third_tid", req.tid.tid, 2);
    rst = 1'b1;
    #1;
    chk("mr_async_req_valid", req_valid, 0);
    chk("mr_async_busy", busy, 0);
    chk("mr_async_desc_ready", desc_ready, 1);
    chk("mr_async_state", state_dbg, S_IDLE);
    cyc(); rst = 1'b0; drive_resp(2'd0, 4'd0, d0); #1;
    chk("mr_stale_no_rdata", rdata_valid, 0);
    cyc(); resp_valid = 1'b0; #1;
    chk("mr_stale_err", err_unexp, 1);
    chk("mr_stale_idle", busy, 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
